// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// vram_arbiter
// Shares one synchronous single-port frame-buffer RAM (FB_W x FB_H entries,
// each covering a 4x4 block of the 640x480 screen) between three requesters:
//   - display reads, one per active-video pixel tick (always wins its slot)
//   - a full-buffer clear engine (beats the writer)
//   - a game-logic writer with a req/ack handshake
//
// Ports:
//   clk, reset               system clock (4x pixel clock), async active-high reset
//   p_tick, video_on, x, y   sync-generator timing inputs
//   wr_req/wr_addr/wr_data   writer request, held until wr_ack
//   wr_ack                   one-cycle ack, high in the cycle the write is on ram_*
//   clr_start/clr_data       start a clear with the given fill value
//   clr_busy                 high while a clear is running
//   ram_en/we/addr/wdata     registered RAM command
//   ram_rdata                RAM read data, valid the cycle after a read
//   pix_data                 pixel to the colour stage, 3 cycles after the slot
//
// Build option: define VRAM_VBLANK_WR_EN to restrict clear and writer
// accesses to vertical blanking (y >= FB_H*4). Display reads are unaffected.
module vram_arbiter #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int DW   = 8,
  parameter int AW   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  output logic          clr_busy,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] pix_data
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] clr_val_q, clr_val_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          wr_ack_q, wr_ack_d;
  // Pixel pipeline: stage 1 is the cycle the read is on ram_*, stage 2 the
  // cycle ram_rdata is valid. vis marks a real read, tick marks any p_tick.
  logic          tick1_q, tick1_d, vis1_q, vis1_d;
  logic          tick2_q, tick2_d, vis2_q, vis2_d;
  logic [DW-1:0] pix_data_q, pix_data_d;

  logic          disp_slot;
  logic          free_cycle;
  logic          bg_ok;
  logic [AW-1:0] disp_addr;
  logic          unused_xy_lsbs;

  // Each entry covers 4x4 screen pixels, so only x[9:2] and y[9:2] address it.
  assign disp_addr      = AW'(y[9:2]) * AW'(FB_W) + AW'(x[9:2]);
  assign unused_xy_lsbs = ^{x[1:0], y[1:0]};

  assign disp_slot  = p_tick && video_on;
  // The cycle after a writer grant is withheld from everyone but display, which
  // both spaces writer grants two cycles apart and keeps ack a single pulse.
  assign free_cycle = !disp_slot && !wr_ack_q;

`ifdef VRAM_VBLANK_WR_EN
  assign bg_ok = (y >= 10'(FB_H * 4));
`else
  assign bg_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_val_d   = clr_val_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wr_ack_d    = 1'b0;

    if (disp_slot) begin
      ram_en_d   = 1'b1;
      ram_addr_d = disp_addr;
    end

    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          // Accepting a clear only changes state; the first clear write waits
          // for a later free cycle, and the writer loses this cycle.
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          clr_val_d = clr_data;
        end else if (wr_req && free_cycle && bg_ok) begin
          wr_ack_d = 1'b1;
          // Out-of-range addresses are acknowledged without touching the RAM.
          if (wr_addr <= LAST_ADDR) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
          end
        end
      end
      S_CLEAR: begin
        if (free_cycle && bg_ok) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = clr_cnt_q;
          ram_wdata_d = clr_val_q;
          // Leaving CLEAR with the last write makes clr_busy fall in the same
          // cycle that write is presented on ram_*.
          if (clr_cnt_q == LAST_ADDR) begin
            state_d = S_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tick1_d    = p_tick;
    vis1_d     = disp_slot;
    tick2_d    = tick1_q;
    vis2_d     = vis1_q;
    pix_data_d = pix_data_q;
    if (tick2_q) begin
      pix_data_d = vis2_q ? ram_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= '0;
      clr_val_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      tick1_q     <= 1'b0;
      vis1_q      <= 1'b0;
      tick2_q     <= 1'b0;
      vis2_q      <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_val_q   <= clr_val_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wr_ack_q    <= wr_ack_d;
      tick1_q     <= tick1_d;
      vis1_q      <= vis1_d;
      tick2_q     <= tick2_d;
      vis2_q      <= vis2_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign clr_busy  = (state_q == S_CLEAR);
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign pix_data  = pix_data_q;

endmodule
